video_timing_gen: RTL
=====================

// Module: video_timing_gen
// PURPOSE
//  Parametrised raster timing generator for the DVI pixel path, driven by the divided pixel clock.
//  Produces DE/HS/VS, pixel coordinates, start-of-frame/end-of-line strobes and a frame count for the image
//  generator. Supports any mode via parameters, selectable sync polarity, and a run/stop enable.
//  Stopping always completes the current frame, so the sink never sees a partial frame.
// PARAMETERS
//  HAC 640 horizontal active pixels;  HFP 16 h front porch;  HSP 96 h sync pulse;  HBP 48 h back porch
//  VAC 480 vertical active lines;     VFP 10 v front porch;  VSP 2 v sync lines;   VBP 33 v back porch
//  HS_POL 0 active level of o_hs (0 = negative sync);  VS_POL 0 active level of o_vs
//  XW 10 width of o_x;  YW 10 width of o_y;  FW 8 width of o_frame
// PORTS
//  i_clk    in  1   pixel clock
//  i_rstn   in  1   asynchronous active-low reset
//  i_en     in  1   run request; sampled every cycle
//  o_de     out 1   data enable, high in the active area
//  o_hs     out 1   horizontal sync, level per HS_POL
//  o_vs     out 1   vertical sync, level per VS_POL
//  o_x      out XW  pixel column while o_de=1, else 0
//  o_y      out YW  pixel line while o_de=1, else 0
//  o_sof    out 1   one-cycle strobe with pixel (0,0)
//  o_eol    out 1   one-cycle strobe with the last pixel of each active line (x=HAC-1, o_de=1)
//  o_frame  out FW  completed-frame count, wraps modulo 2^FW
//  o_busy   out 1   high while state is RUN or STOP
// BEHAVIOUR
//  - HTOT=HAC+HFP+HSP+HBP; VTOT=VAC+VFP+VSP+VBP. Internal counters: h 0..HTOT-1, v 0..VTOT-1.
//  - Line order: active, front porch, sync, back porch. Frame order is the same, in whole lines.
//  - Counter update: when h=HTOT-1, h wraps to 0 and v advances; when v=VTOT-1 and h=HTOT-1, both wrap to 0.
//  - Outputs are registered: values for counter state (h,v) appear on the edge after the counters hold (h,v).
//    Latency is 1 cycle.
//  - de = (h<HAC)&&(v<VAC).
//  - hs active for HAC+HFP <= h < HAC+HFP+HSP.
//  - vs active for VAC+VFP <= v < VAC+VFP+VSP, for every h on those lines.
//  - Reset (asynchronous, any time, including mid-frame): state=IDLE, h=v=0, o_de=0, o_hs=~HS_POL,
//    o_vs=~VS_POL, o_x=0, o_y=0, o_sof=0, o_eol=0, o_frame=0, o_busy=0.
//  - FSM:
//    - IDLE: counters held at 0, outputs at reset levels except o_frame, which is held.
//      i_en=1 -> RUN; counters begin advancing on the following edge.
//    - RUN: counters advance. i_en=0 -> STOP.
//    - STOP: counters advance.
//      - i_en=1 -> RUN with no gap or counter disturbance.
//      - Last pixel of the frame (h=HTOT-1, v=VTOT-1) with i_en=0 -> IDLE; counters return to 0.
//      - i_en=1 on the last pixel -> RUN, and the next frame starts seamlessly.
//  - o_frame increments by 1 on the wrap from the last pixel of the frame, in both RUN and STOP.
//    FW-bit wrap: 2^FW-1 -> 0.
//  - o_busy = (state!=IDLE), registered with the other outputs.
//  - Elaboration errors:
//    - HAC, HSP, VAC or VSP equal to 0;
//    - HTOT > 2^XW or VTOT > 2^YW (the internal counters use XW/YW bits);
//    - HS_POL or VS_POL not 0 or 1.
// STRUCTURE
//  - Shared include video_modes.vh: localparam sets for VGA 640x480@60, SVGA 800x600@60 and 720p
//    (HAC..VBP and polarities). The top level selects one set.
//  - One natural sub-module, vtg_wrap_counter (modulo-N counter with enable and a wrap strobe).
//    It is instantiated twice: h uses enable = run; v uses enable = the h wrap strobe.
//  - FSM, decode and output registers stay in this module.
// TESTING (small mode: HAC=4 HFP=1 HSP=2 HBP=1 VAC=3 VFP=1 VSP=1 VBP=1 HS_POL=0 VS_POL=1;
//          HTOT=8, VTOT=6, 48 cycles per frame)
//  1. Release reset, i_en=1 from t0: o_sof pulses once per 48 cycles.
//     Each line: o_de high 4 cycles with o_x=0..3, o_eol on x=3, o_hs low exactly 2 cycles, 1 cycle after DE falls.
//  2. Across a full frame: o_de high on lines 0..2 only; o_vs=1 for exactly 8 consecutive cycles (line 4);
//     o_y=0..2; o_frame steps 0->1 at the frame wrap.
//  3. Drop i_en at line 1, x=2: the frame completes, then o_busy=0 and o_hs=1, o_vs=0, o_de=0 held;
//     o_frame holds 1; no o_sof while IDLE.
//  4. Drop i_en at line 2, re-raise it 5 cycles later: no phase change. o_sof period stays 48 and o_busy stays 1.
//  5. With FW=2, run 5 frames: o_frame sequence 1,2,3,0,1.
//  6. Assert i_rstn=0 mid-sync (line 4): all outputs take reset values immediately, without waiting for a clock edge.
//     After release with i_en=1, the first o_sof follows the same 2-edge latency as in scenario 1.

Source files
------------

// File: rtl/video_timing_gen_pkg.sv
// Shared types and display mode sets for the raster timing generator.
package video_timing_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } vtg_state_e;

   // VGA 640x480@60 (25.175 MHz), negative syncs
   localparam int VGA_HAC    = 640;
   localparam int VGA_HFP    = 16;
   localparam int VGA_HSP    = 96;
   localparam int VGA_HBP    = 48;
   localparam int VGA_VAC    = 480;
   localparam int VGA_VFP    = 10;
   localparam int VGA_VSP    = 2;
   localparam int VGA_VBP    = 33;
   localparam int VGA_HS_POL = 0;
   localparam int VGA_VS_POL = 0;

   // SVGA 800x600@60 (40 MHz), positive syncs
   localparam int SVGA_HAC    = 800;
   localparam int SVGA_HFP    = 40;
   localparam int SVGA_HSP    = 128;
   localparam int SVGA_HBP    = 88;
   localparam int SVGA_VAC    = 600;
   localparam int SVGA_VFP    = 1;
   localparam int SVGA_VSP    = 4;
   localparam int SVGA_VBP    = 23;
   localparam int SVGA_HS_POL = 1;
   localparam int SVGA_VS_POL = 1;

   // 1280x720@60 (74.25 MHz), positive syncs
   localparam int HD720_HAC    = 1280;
   localparam int HD720_HFP    = 110;
   localparam int HD720_HSP    = 40;
   localparam int HD720_HBP    = 220;
   localparam int HD720_VAC    = 720;
   localparam int HD720_VFP    = 5;
   localparam int HD720_VSP    = 5;
   localparam int HD720_VBP    = 20;
   localparam int HD720_HS_POL = 1;
   localparam int HD720_VS_POL = 1;

   // Sync polarity parameters are single-bit levels
   function automatic bit pol_ok(input int p);
      return (p == 0) || (p == 1);
   endfunction

endpackage

// File: rtl/vtg_wrap_counter.sv
// Modulo-N counter with enable; wrap_o flags the enabled step from N-1 back to 0.
module vtg_wrap_counter #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic         clk_i,
   input  logic         rstn_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         wrap_o
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count and wrap strobe
   always_comb begin
      cnt_d  = cnt_q;
      wrap_o = en_i && (cnt_q == LAST);
      if (en_i) cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
   end

   // Count register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: run/stop FSM, h/v counters, registered sync/DE decode.
module video_timing_gen
   import video_timing_gen_pkg::*;
#(
   parameter int HAC    = VGA_HAC,
   parameter int HFP    = VGA_HFP,
   parameter int HSP    = VGA_HSP,
   parameter int HBP    = VGA_HBP,
   parameter int VAC    = VGA_VAC,
   parameter int VFP    = VGA_VFP,
   parameter int VSP    = VGA_VSP,
   parameter int VBP    = VGA_VBP,
   parameter int HS_POL = VGA_HS_POL,
   parameter int VS_POL = VGA_VS_POL,
   parameter int XW     = 10,
   parameter int YW     = 10,
   parameter int FW     = 8
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_en,
   output logic          o_de,
   output logic          o_hs,
   output logic          o_vs,
   output logic [XW-1:0] o_x,
   output logic [YW-1:0] o_y,
   output logic          o_sof,
   output logic          o_eol,
   output logic [FW-1:0] o_frame,
   output logic          o_busy
);

   localparam int   HTOT   = HAC + HFP + HSP + HBP;
   localparam int   VTOT   = VAC + VFP + VSP + VBP;
   localparam logic HS_ACT = HS_POL[0];
   localparam logic VS_ACT = VS_POL[0];

   if (HAC == 0 || HSP == 0 || VAC == 0 || VSP == 0) begin : g_err_zero
      $error("video_timing_gen: HAC, HSP, VAC and VSP must be non-zero");
   end
   if (HTOT > (1 << XW) || VTOT > (1 << YW)) begin : g_err_width
      $error("video_timing_gen: HTOT/VTOT do not fit in XW/YW bits");
   end
   if (!pol_ok(HS_POL) || !pol_ok(VS_POL)) begin : g_err_pol
      $error("video_timing_gen: HS_POL and VS_POL must be 0 or 1");
   end

   vtg_state_e    state_q, state_d;
   logic          run;
   logic [XW-1:0] h;
   logic [YW-1:0] v;
   logic          h_wrap, v_wrap;

   logic          de_q, de_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          sof_q, sof_d;
   logic          eol_q, eol_d;
   logic [FW-1:0] frame_q, frame_d;
   logic          busy_q, busy_d;

   assign run = (state_q != ST_IDLE);

   vtg_wrap_counter #(.N(HTOT), .W(XW)) u_hcnt (
      .clk_i  (i_clk),
      .rstn_i (i_rstn),
      .en_i   (run),
      .cnt_o  (h),
      .wrap_o (h_wrap)
   );

   // v_wrap is therefore the step off the last pixel of the frame
   vtg_wrap_counter #(.N(VTOT), .W(YW)) u_vcnt (
      .clk_i  (i_clk),
      .rstn_i (i_rstn),
      .en_i   (h_wrap),
      .cnt_o  (v),
      .wrap_o (v_wrap)
   );

   // Run/stop control; STOP only drops to IDLE on the frame wrap, so frames are never cut
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (i_en) state_d = ST_RUN;
         ST_RUN:  if (!i_en) state_d = ST_STOP;
         ST_STOP: begin
            if (i_en)        state_d = ST_RUN;
            else if (v_wrap) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Decode of the current (h,v); idle forces inactive levels but keeps the frame count
   always_comb begin
      de_d    = 1'b0;
      hs_d    = ~HS_ACT;
      vs_d    = ~VS_ACT;
      x_d     = '0;
      y_d     = '0;
      sof_d   = 1'b0;
      eol_d   = 1'b0;
      busy_d  = run;
      frame_d = v_wrap ? frame_q + 1'b1 : frame_q;
      if (run) begin
         de_d  = (int'(h) < HAC) && (int'(v) < VAC);
         hs_d  = ((int'(h) >= HAC + HFP) && (int'(h) < HAC + HFP + HSP)) ? HS_ACT : ~HS_ACT;
         vs_d  = ((int'(v) >= VAC + VFP) && (int'(v) < VAC + VFP + VSP)) ? VS_ACT : ~VS_ACT;
         x_d   = de_d ? h : '0;
         y_d   = de_d ? v : '0;
         sof_d = de_d && (h == '0) && (v == '0);
         eol_d = de_d && (int'(h) == HAC - 1);
      end
   end

   // Output registers
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         de_q    <= 1'b0;
         hs_q    <= ~HS_ACT;
         vs_q    <= ~VS_ACT;
         x_q     <= '0;
         y_q     <= '0;
         sof_q   <= 1'b0;
         eol_q   <= 1'b0;
         frame_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         de_q    <= de_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         x_q     <= x_d;
         y_q     <= y_d;
         sof_q   <= sof_d;
         eol_q   <= eol_d;
         frame_q <= frame_d;
         busy_q  <= busy_d;
      end
   end

   assign o_de    = de_q;
   assign o_hs    = hs_q;
   assign o_vs    = vs_q;
   assign o_x     = x_q;
   assign o_y     = y_q;
   assign o_sof   = sof_q;
   assign o_eol   = eol_q;
   assign o_frame = frame_q;
   assign o_busy  = busy_q;

endmodule
